accel_tilt_filter: RTL and testbench
====================================

// Module: accel_tilt_filter
// PURPOSE
//  Conditioning stage between AccelerometerCtl (9-bit offset-binary X/Y, 0g = 256) and the Ball physics block.
//  Decimates raw samples to a fixed rate and box-car averages them. Subtracts a user-captured level (calibration) offset.
//  Saturates and applies a dead zone. Emits signed tilt values with a 1-cycle valid strobe, so the ball stays still on a level board.
// PARAMETERS
//  CLK_FREQ_HZ      100_000_000  system clock frequency
//  SAMPLE_RATE_HZ   1000         sample tick rate; period = CLK_FREQ_HZ/SAMPLE_RATE_HZ clocks
//  AVG_LOG2         3            log2 of samples per output window (8)
//  CAL_LOG2         4            log2 of samples averaged for calibration (16)
//  DEADZONE         6            dead-zone half-width in LSBs (0..63)
//  SIMULATE         0            1 = sample tick every 4 clocks (bench speed-up)
// PORTS
//  clk         in   1  100 MHz system clock
//  reset       in   1  synchronous, active-high reset
//  accel_x_in  in   9  raw X, offset binary (256 = 0g)
//  accel_y_in  in   9  raw Y, offset binary
//  cal_req     in   1  1-cycle pulse: capture current attitude as level
//  tilt_x      out  9  signed two's-complement filtered X, range -255..+255
//  tilt_y      out  9  signed filtered Y, range -255..+255
//  tilt_valid  out  1  1-cycle pulse when tilt_x/tilt_y update
//  cal_busy    out  1  high while calibration window in progress
//  cal_done    out  1  1-cycle pulse when new offsets loaded
// BEHAVIOUR
//  - One clock and one reset (clk; synchronous, active-high reset). No other clock domains; inputs are already synchronous to clk.
//  - Reset: tilt_x=0, tilt_y=0, tilt_valid=0, cal_busy=0, cal_done=0; offsets=0; accumulators, sample count and tick counter cleared; FSM=RUN.
//  - Tick counter: free-running 0..PERIOD-1. tick=1 for one clock at terminal count.
//    First tick is PERIOD clocks after reset is released.
//  - Signed conversion: s = {~in[8], in[7:0]}, i.e. in-256.
//  - FSM RUN: on each tick, add sx/sy to acc_x/acc_y (width 9+CAL_LOG2, sign-extended) and increment cnt.
//    - On the tick that is sample 2^AVG_LOG2, the window closes.
//    - avg = acc >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
//    - d = avg - offset (10-bit).
//    - Saturate d to [-255,+255].
//    - Dead zone: |d|<=DEADZONE -> 0; otherwise d - sign(d)*DEADZONE.
//    - acc and cnt clear the same clock the window closes.
//  - Latency: tilt_x/tilt_y are registered and tilt_valid is high exactly 1 clock, 2 clocks after the closing tick.
//    Stage 1: avg/offset/saturate. Stage 2: dead zone/output.
//  - FSM RUN -> CAL on cal_req (same clock). The partial window is discarded: acc and cnt clear. cal_busy=1 from the next clock.
//  - FSM CAL: accumulate 2^CAL_LOG2 ticks. On the final tick, offset = acc >>> CAL_LOG2 (arithmetic shift) for both axes.
//    Then cal_done pulses 1 clock, cal_busy drops the same clock, FSM -> RUN with a fresh window.
//  - In CAL: tilt_x/tilt_y hold their last value and no tilt_valid is issued.
//    A window in the stage-1/2 pipeline when cal_req arrives still completes and emits.
//  - cal_req while in CAL is ignored.
//  - cal_req coincident with a RUN closing tick: the window result is emitted, then CAL starts.
//  - reset has priority over all events, including mid-CAL: offsets return to 0 and no cal_done is issued.
//  - No overflow: acc width covers 2^CAL_LOG2 * 256 worst case. cnt wraps only by explicit clear.
// CONFIGURATION
//  - Macro TILT_DEADZONE_EN.
//    Defined: the dead-zone step above is applied.
//    Undefined: the dead-zone step is bypassed (output = saturated d) and the DEADZONE parameter is ignored.
//    Latency is unchanged in both builds (stage 2 stays a register).
// TESTING  (SIMULATE=1, defaults, TILT_DEADZONE_EN defined unless noted)
//  1. Hold x=296, y=236 from reset -> after 8 ticks tilt_x=+34, tilt_y=-14.
//     tilt_valid pulses once per 8 ticks, 2 clocks after the 8th tick.
//  2. Dead zone: x=261 -> 0; x=251 -> 0; x=263 -> +1; x=249 -> -1.
//     Without TILT_DEADZONE_EN: x=261 -> +5; x=253 -> -3 (arithmetic avg, no -2).
//  3. Averaging: x alternates 272/256 per tick -> avg 8 -> tilt_x=+2.
//     Constant x=0 (no cal) -> tilt_x=-255+6=-249.
//  4. Calibration: hold x=276, y=246, pulse cal_req -> cal_busy 16 ticks, then cal_done 1 clock.
//     Next window tilt_x=0, tilt_y=0. Then x=306 -> tilt_x=+24.
//  5. Saturation: calibrate at x=0 (offset -256), then x=511 -> d=511 saturates to 255 -> tilt_x=+249.
//  6. Assert reset for 1 clock mid-CAL (tick 7 of 16) -> all outputs 0, cal_busy=0, no cal_done.
//     First tilt_valid comes only after 8 new ticks, with offset 0.

Source files
------------

// File: rtl/accel_tilt_filter_if.sv
// Accelerometer-side inputs and filtered-tilt outputs of accel_tilt_filter.
// master = sample source / consumer side, slave = the filter itself.
interface accel_tilt_filter_if;
  logic        [8:0] accel_x_in;
  logic        [8:0] accel_y_in;
  logic              cal_req;
  logic signed [8:0] tilt_x;
  logic signed [8:0] tilt_y;
  logic              tilt_valid;
  logic              cal_busy;
  logic              cal_done;

  modport master (
    output accel_x_in, accel_y_in, cal_req,
    input  tilt_x, tilt_y, tilt_valid, cal_busy, cal_done
  );

  modport slave (
    input  accel_x_in, accel_y_in, cal_req,
    output tilt_x, tilt_y, tilt_valid, cal_busy, cal_done
  );
endinterface

// File: rtl/accel_tilt_filter.sv
// Decimating box-car tilt filter with level calibration, saturation and optional dead zone.
// Optional feature macro: TILT_DEADZONE_EN (defined = dead zone applied in output stage).
module accel_tilt_filter #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int SAMPLE_RATE_HZ = 1000,
  parameter int AVG_LOG2       = 3,
  parameter int CAL_LOG2       = 4,
  parameter int DEADZONE       = 6,
  parameter int SIMULATE       = 0
) (
  input  logic                clk,
  input  logic                reset,
  accel_tilt_filter_if.slave  bus
);
  localparam int PERIOD   = (SIMULATE != 0) ? 4 : (CLK_FREQ_HZ / SAMPLE_RATE_HZ);
  localparam int TICK_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int WIN_LOG2 = (AVG_LOG2 > CAL_LOG2) ? AVG_LOG2 : CAL_LOG2;
  localparam int ACC_W    = 9 + WIN_LOG2;
  localparam int CNT_W    = WIN_LOG2 + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  AVG_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  CAL_LAST  = CNT_W'((1 << CAL_LOG2) - 1);

  if (DEADZONE < 0 || DEADZONE > 63) begin : g_bad_deadzone
    $error("accel_tilt_filter: DEADZONE must be in 0..63");
  end

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CAL = 1'b1} state_t;

  state_t                   r_state;
  logic [TICK_W-1:0]        r_tick_cnt;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc_x, r_acc_y;
  logic signed [8:0]        r_off_x, r_off_y;
  logic                     r_s1_valid;
  logic signed [8:0]        r_s1_x, r_s1_y;
  logic                     r_tilt_valid, r_cal_busy, r_cal_done;
  logic signed [8:0]        r_tilt_x, r_tilt_y;

  logic                     w_tick;
  logic signed [8:0]        w_sx, w_sy, w_avg_x, w_avg_y, w_sat_x, w_sat_y;
  logic signed [ACC_W-1:0]  w_acc_nx, w_acc_ny;
  logic signed [9:0]        w_d_x, w_d_y;

  function automatic logic signed [8:0] sat9(input logic signed [9:0] d);
    logic signed [8:0] q;
    if (d > 10'sd255)       q = 9'sd255;
    else if (d < -10'sd255) q = -9'sd255;
    else                    q = 9'(d);
    return q;
  endfunction

`ifdef TILT_DEADZONE_EN
  localparam logic signed [8:0] DZ = 9'(DEADZONE);
`endif

  function automatic logic signed [8:0] shape(input logic signed [8:0] d);
    logic signed [8:0] q;
`ifdef TILT_DEADZONE_EN
    if (d > DZ)       q = d - DZ;
    else if (d < -DZ) q = d + DZ;
    else              q = 9'sd0;
`else
    q = d;
`endif
    return q;
  endfunction

  // Offset binary to two's complement is just an MSB flip.
  assign w_sx     = {~bus.accel_x_in[8], bus.accel_x_in[7:0]};
  assign w_sy     = {~bus.accel_y_in[8], bus.accel_y_in[7:0]};
  assign w_acc_nx = r_acc_x + {{(ACC_W-9){w_sx[8]}}, w_sx};
  assign w_acc_ny = r_acc_y + {{(ACC_W-9){w_sy[8]}}, w_sy};
  assign w_avg_x  = w_acc_nx[AVG_LOG2 +: 9];
  assign w_avg_y  = w_acc_ny[AVG_LOG2 +: 9];
  assign w_d_x    = {w_avg_x[8], w_avg_x} - {r_off_x[8], r_off_x};
  assign w_d_y    = {w_avg_y[8], w_avg_y} - {r_off_y[8], r_off_y};
  assign w_sat_x  = sat9(w_d_x);
  assign w_sat_y  = sat9(w_d_y);
  assign w_tick   = (r_tick_cnt == TICK_LAST);

  // Free-running sample-rate divider.
  always_ff @(posedge clk) begin
    if (reset)       r_tick_cnt <= {TICK_W{1'b0}};
    else if (w_tick) r_tick_cnt <= {TICK_W{1'b0}};
    else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  // RUN/CAL control, accumulation and the two-stage output pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_cnt        <= {CNT_W{1'b0}};
      r_acc_x      <= {ACC_W{1'b0}};
      r_acc_y      <= {ACC_W{1'b0}};
      r_off_x      <= 9'sd0;
      r_off_y      <= 9'sd0;
      r_s1_valid   <= 1'b0;
      r_s1_x       <= 9'sd0;
      r_s1_y       <= 9'sd0;
      r_tilt_valid <= 1'b0;
      r_tilt_x     <= 9'sd0;
      r_tilt_y     <= 9'sd0;
      r_cal_busy   <= 1'b0;
      r_cal_done   <= 1'b0;
    end else begin
      r_s1_valid   <= 1'b0;
      r_cal_done   <= 1'b0;
      r_tilt_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_tilt_x <= shape(r_s1_x);
        r_tilt_y <= shape(r_s1_y);
      end
      case (r_state)
        ST_RUN: begin
          if (w_tick) begin
            if (r_cnt == AVG_LAST) begin
              r_s1_valid <= 1'b1;
              r_s1_x     <= w_sat_x;
              r_s1_y     <= w_sat_y;
              r_acc_x    <= {ACC_W{1'b0}};
              r_acc_y    <= {ACC_W{1'b0}};
              r_cnt      <= {CNT_W{1'b0}};
            end else begin
              r_acc_x <= w_acc_nx;
              r_acc_y <= w_acc_ny;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          // A calibration request discards the partial window; a just-closed one still emits.
          if (bus.cal_req) begin
            r_state    <= ST_CAL;
            r_cal_busy <= 1'b1;
            r_acc_x    <= {ACC_W{1'b0}};
            r_acc_y    <= {ACC_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
          end
        end
        ST_CAL: begin
          if (w_tick) begin
            if (r_cnt == CAL_LAST) begin
              r_off_x    <= w_acc_nx[CAL_LOG2 +: 9];
              r_off_y    <= w_acc_ny[CAL_LOG2 +: 9];
              r_cal_done <= 1'b1;
              r_cal_busy <= 1'b0;
              r_state    <= ST_RUN;
              r_acc_x    <= {ACC_W{1'b0}};
              r_acc_y    <= {ACC_W{1'b0}};
              r_cnt      <= {CNT_W{1'b0}};
            end else begin
              r_acc_x <= w_acc_nx;
              r_acc_y <= w_acc_ny;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_cal_busy <= 1'b0;
          r_acc_x    <= {ACC_W{1'b0}};
          r_acc_y    <= {ACC_W{1'b0}};
          r_cnt      <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.tilt_x     = r_tilt_x;
  assign bus.tilt_y     = r_tilt_y;
  assign bus.tilt_valid = r_tilt_valid;
  assign bus.cal_busy   = r_cal_busy;
  assign bus.cal_done   = r_cal_done;
endmodule

// File: tb/tb_accel_tilt_filter.sv
// Randomized self-checking bench for accel_tilt_filter (SIMULATE=1, tick every 4 clocks).
// Reference model works on sample lists and integer arithmetic; honours TILT_DEADZONE_EN.
module tb_accel_tilt_filter;
  localparam int PERIOD = 4;
  localparam int AVG_N  = 8;
  localparam int CAL_N  = 16;
  localparam int DZ     = 6;

  logic clk = 1'b0;
  logic reset;
  accel_tilt_filter_if bus ();

  accel_tilt_filter #(.SIMULATE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit m_cal;
  int qx[$];
  int qy[$];
  int off_x, off_y, edge_n;
  int e_tx, e_ty, e_valid, e_busy, e_done;
  bit pend;
  int pend_x, pend_y;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int shape(input int d);
    int s;
    s = (d > 255) ? 255 : ((d < -255) ? -255 : d);
`ifdef TILT_DEADZONE_EN
    if (s > DZ) return s - DZ;
    else if (s < -DZ) return s + DZ;
    else return 0;
`else
    return s;
`endif
  endfunction

  task automatic model(input bit rst, input int x, input int y, input bit req);
    bit tick;
    e_valid = 0;
    e_done  = 0;
    if (rst) begin
      m_cal = 1'b0; qx.delete(); qy.delete();
      off_x = 0; off_y = 0; e_tx = 0; e_ty = 0; e_busy = 0;
      pend = 1'b0; edge_n = 0;
    end else begin
      edge_n++;
      if (pend) begin
        e_valid = 1; e_tx = pend_x; e_ty = pend_y; pend = 1'b0;
      end
      tick = (edge_n % PERIOD == 0);
      if (!m_cal) begin
        if (tick) begin
          qx.push_back(x - 256); qy.push_back(y - 256);
          if (qx.size() == AVG_N) begin
            pend   = 1'b1;
            pend_x = shape(floor_div(qx.sum(), AVG_N) - off_x);
            pend_y = shape(floor_div(qy.sum(), AVG_N) - off_y);
            qx.delete(); qy.delete();
          end
        end
        if (req) begin
          m_cal = 1'b1; e_busy = 1; qx.delete(); qy.delete();
        end
      end else if (tick) begin
        qx.push_back(x - 256); qy.push_back(y - 256);
        if (qx.size() == CAL_N) begin
          off_x = floor_div(qx.sum(), CAL_N);
          off_y = floor_div(qy.sum(), CAL_N);
          e_done = 1; e_busy = 0; m_cal = 1'b0;
          qx.delete(); qy.delete();
        end
      end
    end
  endtask

  task automatic step(input bit rst, input int x, input int y, input bit req);
    reset          = rst;
    bus.accel_x_in = 9'(x);
    bus.accel_y_in = 9'(y);
    bus.cal_req    = req;
    model(rst, x, y, req);
    @(negedge clk);
    chk("tilt_valid", int'(bus.tilt_valid), e_valid);
    chk("cal_busy",   int'(bus.cal_busy),   e_busy);
    chk("cal_done",   int'(bus.cal_done),   e_done);
    chk("tilt_x",     int'($signed(bus.tilt_x)), e_tx);
    chk("tilt_y",     int'($signed(bus.tilt_y)), e_ty);
  endtask

  task automatic hold(input int cycles, input int x, input int y);
    for (int i = 0; i < cycles; i++) step(1'b0, x, y, 1'b0);
  endtask

  task automatic rand_run(input int cycles, input int lo, input int hi, input int req_pct);
    for (int i = 0; i < cycles; i++)
      step(1'b0, int'($urandom_range(hi, lo)), int'($urandom_range(hi, lo)),
           ($urandom_range(99, 0) < req_pct));
  endtask

  initial begin
    reset = 1'b1;
    bus.accel_x_in = 9'd256; bus.accel_y_in = 9'd256; bus.cal_req = 1'b0;
    step(1'b1, 256, 256, 1'b0);
    step(1'b1, 256, 256, 1'b0);

    // steady tilt, dead-zone edges, averaging, negative saturation
    hold(80, 296, 236);
    hold(32, 261, 251);
    hold(32, 263, 249);
    hold(32, 253, 256);
    for (int i = 0; i < 64; i++) step(1'b0, ((((edge_n + 1) / PERIOD) % 2) == 0) ? 272 : 256, 256, 1'b0);
    hold(64, 0, 511);

    // calibration at a tilted attitude, then a relative tilt
    step(1'b0, 276, 246, 1'b1);
    hold(100, 276, 246);
    hold(64, 306, 256);

    // cal_req exactly on a closing tick, then a second request during CAL
    for (int i = 0; i < 200 && !(!m_cal && ((edge_n + 1) % PERIOD == 0) && qx.size() == AVG_N - 1); i++)
      step(1'b0, 300, 220, 1'b0);
    step(1'b0, 300, 220, 1'b1);
    hold(12, 300, 220);
    step(1'b0, 300, 220, 1'b1);
    hold(90, 300, 220);

    // calibrate at x=0 then full-scale positive to hit saturation
    step(1'b0, 0, 511, 1'b1);
    hold(80, 0, 511);
    hold(64, 511, 0);

    // reset during calibration after 6 of 16 samples
    step(1'b0, 280, 240, 1'b1);
    for (int i = 0; i < 200 && !(m_cal && qx.size() == 6 && ((edge_n + 1) % PERIOD == 0)); i++)
      step(1'b0, 280, 240, 1'b0);
    step(1'b1, 280, 240, 1'b0);
    hold(70, 280, 240);

    // random sweeps: near level and full range with sporadic calibration requests
    rand_run(800, 244, 268, 1);
    rand_run(1200, 0, 511, 1);
    rand_run(400, 0, 511, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
